wave_uart_sched: RTL and testbench
==================================

# wave_uart_sched

Sample scheduler between the waveform generators and the UART transmitter. It issues the periodic `ce` strobe that advances a generator and captures the resulting 10-bit two's-complement sample. It then streams the sample to the UART TX as a 3-byte frame over a valid/ready handshake. It also detects and counts sample ticks lost while a frame is still in flight.

## Interface
- `DIV_W`, 16: width of the sample-period divider.
- `SYNC_BYTE`, 8'hA5: first byte of every frame.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `en` in 1: streaming enable; level-sensitive.
- `div` in DIV_W: sample period minus one, in `clk` cycles.
- `clr_ovr` in 1: single-cycle pulse that clears `overrun_cnt`.
- `sample_in` in 10: generator output, two's complement.
- `gen_ce` out 1: registered one-cycle advance strobe to the generator.
- `tx_data` out 8: byte to the UART TX.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: the UART TX accepts the byte this cycle.
- `busy` out 1: the frame FSM is not in IDLE.
- `overrun_cnt` out 8: saturating count of dropped ticks.

## Operation
- Divider `cnt`:
  - Reset value is 0.
  - While `en`=1: if `cnt >= div`, then `cnt<=0` and `gen_ce<=1`; otherwise `cnt<=cnt+1` and `gen_ce<=0`.
  - While `en`=0: `cnt<=0`, `gen_ce<=0`.
  - The `>=` comparison makes a mid-count reduction of `div` take effect without a wrap-around. `div`=0 gives `gen_ce` high every cycle.
- `gen_ce` is always forwarded to the generator, even when the FSM is busy. This keeps the waveform's time base intact.
- FSM states: IDLE, CAPT, SYNC, HI, LO.
  - IDLE: on `gen_ce`=1, go to CAPT.
  - CAPT: on the next edge, latch `sample_in` into `smp`, drive `tx_data<=SYNC_BYTE` and `tx_valid<=1`, go to SYNC.
  - SYNC: on `tx_valid&tx_ready`, drive `tx_data<={{6{smp[9]}},smp[9:8]}` and go to HI.
  - HI: on accept, drive `tx_data<=smp[7:0]` and go to LO.
  - LO: on accept, drive `tx_valid<=0` and go to IDLE.
- Handshake rules:
  - A transfer happens on any edge where `tx_valid&tx_ready`=1.
  - `tx_data` is stable while `tx_valid`=1 and no transfer has occurred.
  - `tx_valid` does not drop between the bytes of a frame (no bubbles when `tx_ready` stays high).
  - `tx_ready` is ignored while `tx_valid`=0.
- Overrun: a cycle with `gen_ce`=1 and state≠IDLE drops that sample.
  - `overrun_cnt` increments and saturates at 255.
  - `clr_ovr` takes priority over an increment in the same cycle; the result is 0.
  - A tick in the same cycle as the LO accept counts as an overrun.
- Deasserting `en` stops new ticks. Any frame already in progress completes normally.
- `busy` = (state≠IDLE), combinational from the state register.
- Reset:
  - Applies on any edge with `rst_n`=0, including mid-frame. A partial frame is abandoned with no flush.
  - Reset values: state=IDLE, `cnt`=0, `smp`=0, `gen_ce`=0, `tx_valid`=0, `tx_data`=8'h00, `overrun_cnt`=0, `busy`=0.

## Timing
- If `en` rises with `cnt`=0 at cycle 0, the first `gen_ce` is at cycle `div`+1. After that, `gen_ce` pulses every `div`+1 cycles.
- Tick at cycle T: CAPT at T+1 (sample sampled at the end of T+1), `tx_valid`=1 with SYNC at T+2.
- With `tx_ready` held at 1, the bytes transfer at the ends of T+2, T+3 and T+4, and the FSM is in IDLE at T+5.
- Minimum loss-free period is 5 cycles (`div`>=4) with `tx_ready` held high. Each stalled `tx_ready` cycle extends the frame by one cycle.
- `sample_in` must be settled one cycle after `gen_ce`. Generators register on `ce`, so they meet this.

## Test plan
- Reset: `rst_n`=0 for 2 cycles with `en`=1 → all outputs at reset values. After release, `gen_ce` first pulses exactly `div`+1 cycles later.
- Basic frame: `div`=9, `tx_ready`=1, `sample_in`=10'h3F0 after the tick →
  - bytes A5, FF, F0 on consecutive cycles starting at T+2;
  - `busy` high for T+1..T+4;
  - `gen_ce` period 10; `overrun_cnt`=0.
- Backpressure: `tx_ready` low for 3 cycles during HI, `sample_in`=10'h105 →
  - `tx_data` held at 8'h01 with `tx_valid` high;
  - LO byte 8'h05 follows the accept;
  - no byte is duplicated or lost.
- Overrun: `div`=3, `tx_ready`=1 → every second tick dropped. `overrun_cnt` reaches 255 and holds. `clr_ovr` together with a dropped tick → 0.
- `en` dropped in HI → HI and LO bytes complete, no further `gen_ce`, `cnt`=0. Re-enabling gives the first tick after `div`+1 cycles.
- Mid-frame reset in SYNC with `tx_ready`=0 → `tx_valid`=0 on the next cycle, state IDLE, and no stale bytes once `en` resumes.

Source files
------------

// File: rtl/wave_uart_sched.sv
// Sample scheduler: issues the periodic generator advance strobe, captures the
// resulting 10-bit sample and streams it to the UART TX as a 3-byte frame
// (sync, sign-extended high bits, low byte). Ticks that arrive while a frame is
// still in flight are dropped and counted.
module wave_uart_sched #(
  parameter int unsigned DIV_W     = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             clr_ovr,
  input  logic [9:0]       sample_in,
  output logic             gen_ce,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic [7:0]       overrun_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPT,
    S_SYNC,
    S_HI,
    S_LO
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             gen_ce_q, gen_ce_d;
  logic [9:0]       smp_q;
  logic [7:0]       tx_data_q;
  logic             tx_valid_q;
  logic [7:0]       ovr_q, ovr_d;
  logic             accept;

  assign accept      = tx_valid_q & tx_ready;
  assign gen_ce      = gen_ce_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign overrun_cnt = ovr_q;

  // Divider next state; >= lets a lowered div take effect without wrapping.
  always_comb begin
    cnt_d    = '0;
    gen_ce_d = 1'b0;
    if (en) begin
      if (cnt_q >= div) begin
        cnt_d    = '0;
        gen_ce_d = 1'b1;
      end else begin
        cnt_d    = cnt_q + 1'b1;
        gen_ce_d = 1'b0;
      end
    end
  end

  // Overrun counter next state: clear wins over a dropped tick, saturates at 255.
  always_comb begin
    ovr_d = ovr_q;
    if (clr_ovr) begin
      ovr_d = '0;
    end else if (gen_ce_q && (state_q != S_IDLE) && (ovr_q != '1)) begin
      ovr_d = ovr_q + 8'd1;
    end
  end

  // Divider and overrun registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      gen_ce_q <= 1'b0;
      ovr_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      gen_ce_q <= gen_ce_d;
      ovr_q    <= ovr_d;
    end
  end

  // Frame FSM with registered TX outputs; tx_valid stays high across all three bytes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      smp_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gen_ce_q) state_q <= S_CAPT;
        end
        S_CAPT: begin
          smp_q      <= sample_in;
          tx_data_q  <= SYNC_BYTE;
          tx_valid_q <= 1'b1;
          state_q    <= S_SYNC;
        end
        S_SYNC: begin
          if (accept) begin
            tx_data_q <= {{6{smp_q[9]}}, smp_q[9:8]};
            state_q   <= S_HI;
          end
        end
        S_HI: begin
          if (accept) begin
            tx_data_q <= smp_q[7:0];
            state_q   <= S_LO;
          end
        end
        S_LO: begin
          if (accept) begin
            tx_valid_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: begin
          tx_valid_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_uart_sched.sv
// Bench for wave_uart_sched: scenario tasks drive stimulus and check timing
// inline; a scoreboard queue holds the frame bytes expected on the TX handshake.
module tb_wave_uart_sched;

  logic        clk = 1'b0;
  logic        rst_n, en, clr_ovr, tx_ready;
  logic [15:0] div;
  logic [9:0]  sample_in;
  logic        gen_ce, tx_valid, busy;
  logic [7:0]  tx_data, overrun_cnt;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] sb_exp;

  always #5 clk = ~clk;

  wave_uart_sched #(.DIV_W(16), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .div        (div),
    .clr_ovr    (clr_ovr),
    .sample_in  (sample_in),
    .gen_ce     (gen_ce),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .overrun_cnt(overrun_cnt)
  );

  // Scoreboard: every handshake transfer pops and compares one expected byte.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got byte %02h, required no transfer", tx_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if (tx_data !== sb_exp) begin
          bad++;
          $display("FAIL sb_byte: got %02h, required %02h", tx_data, sb_exp);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [9:0] s);
    exp_q.push_back(8'hA5);
    exp_q.push_back({{6{s[9]}}, s[9:8]});
    exp_q.push_back(s[7:0]);
  endtask

  task automatic wait_tick(output int c);
    c = 0;
    do begin
      cyc();
      c++;
    end while (gen_ce !== 1'b1 && c < 100);
  endtask

  task automatic start_en(input logic [15:0] d);
    en = 1'b0;
    cyc();
    cyc();
    div = d;
    en  = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (exp_q.size() != 0 || busy !== 1'b0); i++) cyc();
    total++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL drain: pending=%0d busy=%b, required pending=0 busy=0", exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    int c;
    rst_n = 1'b0; en = 1'b1; div = 16'd4; tx_ready = 1'b1; clr_ovr = 1'b0;
    sample_in = 10'h2C7;
    cyc();
    cyc();
    total++; if (gen_ce !== 1'b0)      begin bad++; $display("FAIL rst_gen_ce: got %b, required 0", gen_ce); end
    total++; if (tx_valid !== 1'b0)    begin bad++; $display("FAIL rst_tx_valid: got %b, required 0", tx_valid); end
    total++; if (tx_data !== 8'h00)    begin bad++; $display("FAIL rst_tx_data: got %02h, required 00", tx_data); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
    total++; if (overrun_cnt !== 8'h0) begin bad++; $display("FAIL rst_ovr: got %0d, required 0", overrun_cnt); end
    rst_n = 1'b1;
    wait_tick(c);
    total++; if (c != 5) begin bad++; $display("FAIL rst_first_tick: got cycle %0d, required 5", c); end
    push_frame(10'h2C7);
    en = 1'b0;
    drain();
  endtask

  task automatic test_basic();
    int c;
    logic [7:0] bytes [3];
    bytes[0] = 8'hA5; bytes[1] = 8'hFF; bytes[2] = 8'hF0;
    tx_ready = 1'b1; sample_in = 10'h000;
    start_en(16'd9);
    wait_tick(c);
    total++; if (c != 10) begin bad++; $display("FAIL basic_first_tick: got cycle %0d, required 10", c); end
    sample_in = 10'h3F0;
    push_frame(10'h3F0);
    for (int k = 1; k <= 10; k++) begin
      cyc();
      total++;
      if (busy !== (k >= 1 && k <= 4)) begin
        bad++; $display("FAIL basic_busy: T+%0d got %b, required %b", k, busy, (k >= 1 && k <= 4));
      end
      if (k >= 2 && k <= 4) begin
        total++;
        if (tx_valid !== 1'b1 || tx_data !== bytes[k-2]) begin
          bad++; $display("FAIL basic_byte: T+%0d got v=%b d=%02h, required v=1 d=%02h", k, tx_valid, tx_data, bytes[k-2]);
        end
      end
      if (k == 5) begin
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop: got %b, required 0", tx_valid); end
      end
      total++;
      if (gen_ce !== (k == 10)) begin
        bad++; $display("FAIL basic_period: T+%0d gen_ce got %b, required %b", k, gen_ce, (k == 10));
      end
    end
    push_frame(10'h3F0);
    en = 1'b0;
    total++; if (overrun_cnt !== 8'h0) begin bad++; $display("FAIL basic_ovr: got %0d, required 0", overrun_cnt); end
    drain();
  endtask

  task automatic test_backpressure();
    int c;
    tx_ready = 1'b1; sample_in = 10'h105;
    start_en(16'd9);
    wait_tick(c);
    push_frame(10'h105);
    en = 1'b0;
    cyc();
    cyc();
    cyc();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc();
      total++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
        bad++; $display("FAIL bp_hold: stall %0d got v=%b d=%02h, required v=1 d=01", i, tx_valid, tx_data);
      end
    end
    cyc();
    tx_ready = 1'b1;
    total++; if (tx_data !== 8'h01) begin bad++; $display("FAIL bp_hi_accept: got %02h, required 01", tx_data); end
    cyc();
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h05) begin
      bad++; $display("FAIL bp_lo: got v=%b d=%02h, required v=1 d=05", tx_valid, tx_data);
    end
    cyc();
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL bp_end: got valid %b, required 0", tx_valid); end
    drain();
  endtask

  task automatic test_overrun();
    int model;
    bit cleared;
    bit tick;
    int idx;
    tx_ready = 1'b1; sample_in = 10'h2AA;
    clr_ovr = 1'b1;
    cyc();
    clr_ovr = 1'b0;
    model = 0;
    cleared = 1'b0;
    start_en(16'd3);
    for (int c = 1; c <= 2140; c++) begin
      cyc();
      clr_ovr = 1'b0;
      total++;
      if (overrun_cnt !== model[7:0]) begin
        bad++; $display("FAIL ovr_count: cycle %0d got %0d, required %0d", c, overrun_cnt, model);
      end
      if (c == 2088) begin
        total++; if (overrun_cnt !== 8'd255) begin bad++; $display("FAIL ovr_sat: got %0d, required 255", overrun_cnt); end
      end
      tick = (c % 4 == 0);
      total++;
      if (gen_ce !== tick) begin
        bad++; $display("FAIL ovr_tick: cycle %0d gen_ce got %b, required %b", c, gen_ce, tick);
      end
      if (tick) begin
        idx = c / 4 - 1;
        if (idx % 2 == 0) begin
          push_frame(10'h2AA);
        end else if (!cleared && c >= 2090) begin
          clr_ovr = 1'b1;
          model = 0;
          cleared = 1'b1;
        end else if (model != 255) begin
          model++;
        end
      end
    end
    clr_ovr = 1'b0;
    en = 1'b0;
    drain();
  endtask

  task automatic test_en_drop();
    int c;
    int extra;
    tx_ready = 1'b1; sample_in = 10'h155;
    start_en(16'd9);
    wait_tick(c);
    total++; if (c != 10) begin bad++; $display("FAIL endrop_tick: got cycle %0d, required 10", c); end
    push_frame(10'h155);
    cyc();
    cyc();
    cyc();
    en = 1'b0;
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
      bad++; $display("FAIL endrop_hi: got v=%b d=%02h, required v=1 d=01", tx_valid, tx_data);
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (gen_ce === 1'b1) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL endrop_no_tick: got %0d ticks, required 0", extra); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL endrop_complete: got %0d pending bytes, required 0", exp_q.size()); end
    en = 1'b1;
    wait_tick(c);
    total++; if (c != 10) begin bad++; $display("FAIL endrop_reenable: got cycle %0d, required 10", c); end
    push_frame(10'h155);
    en = 1'b0;
    drain();
  endtask

  task automatic test_mid_reset();
    int c;
    tx_ready = 1'b0; sample_in = 10'h3FF;
    start_en(16'd9);
    wait_tick(c);
    cyc();
    cyc();
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      bad++; $display("FAIL mrst_sync: got v=%b d=%02h, required v=1 d=A5", tx_valid, tx_data);
    end
    rst_n = 1'b0;
    cyc();
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00 || gen_ce !== 1'b0) begin
      bad++; $display("FAIL mrst_state: got v=%b busy=%b d=%02h ce=%b, required 0 0 00 0", tx_valid, busy, tx_data, gen_ce);
    end
    rst_n = 1'b1; tx_ready = 1'b1; sample_in = 10'h0C3;
    wait_tick(c);
    total++; if (c != 10) begin bad++; $display("FAIL mrst_tick: got cycle %0d, required 10", c); end
    push_frame(10'h0C3);
    en = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_en_drop();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
